// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Holds the iteration-counter interface width, the iteration count at which the
// counter carry-out fires, the control FSM state encoding, and a helper that maps
// a requested iteration count to the counter preload value.
// Consumers: mult_iter_ctrl, the datapath and the counter bench.
package mult_pkg;

   localparam int unsigned CNT_W    = 6;   // count bits plus terminal bit
   localparam int unsigned ITER_MAX = 32;  // 2**(CNT_W-1)

   localparam logic [CNT_W-1:0] ITER_MAX_V = CNT_W'(ITER_MAX);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ADD,
      SHIFT,
      DONE
   } state_t;

   // Preload so the counter reaches ITER_MAX after n increments. Out-of-range
   // requests (0 or above ITER_MAX) fall back to the full iteration count.
   function automatic logic [CNT_W-1:0] iter_preload(input logic [CNT_W-1:0] n);
      if (n == '0 || n > ITER_MAX_V) begin
         return '0;
      end
      return ITER_MAX_V - n;
   endfunction

endpackage

// File: rtl/mult_iter_ctrl.sv
// Control FSM for the iterative shift-add multiplier.
// Drives the external iteration counter (clear/load/increment), sequences the
// operand registers and the adder/shifter, and reports busy/done.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     begin an operation (sampled only in IDLE)
//   q0        LSB of the multiplier register, selects add in ADD
//   cnt_co    counter carry-out (count == ITER_MAX)
//   iter_n    requested iteration count (only with MULT_ITER_CTRL_SHORT_ITER_EN)
//   cnt_clr   counter clear (also forced while rst is high)
//   cnt_ld    counter load of cnt_pi
//   cnt_inc   counter increment
//   cnt_pi    counter load value
//   ld_a      load multiplicand register
//   ld_b      load multiplier register / clear accumulator
//   add_en    accumulator += multiplicand
//   shift_en  shift accumulator:multiplier right by one
//   busy      high in every state except IDLE
//   done      one-cycle product-valid pulse
//
// Configuration: define MULT_ITER_CTRL_SHORT_ITER_EN to add the iter_n input and
// preload the counter in INIT instead of clearing it.
module mult_iter_ctrl
   import mult_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             q0,
   input  logic             cnt_co,
`ifdef MULT_ITER_CTRL_SHORT_ITER_EN
   input  logic [CNT_W-1:0] iter_n,
`endif
   output logic             cnt_clr,
   output logic             cnt_ld,
   output logic             cnt_inc,
   output logic [CNT_W-1:0] cnt_pi,
   output logic             ld_a,
   output logic             ld_b,
   output logic             add_en,
   output logic             shift_en,
   output logic             busy,
   output logic             done
);

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef MULT_ITER_CTRL_SHORT_ITER_EN
   // Preload captured with start so iter_n need not be held during the operation.
   logic [CNT_W-1:0] pi_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pi_q <= '0;
      end else if (state_q == IDLE && start) begin
         pi_q <= iter_preload(iter_n);
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_clr  = 1'b0;
      cnt_ld   = 1'b0;
      cnt_inc  = 1'b0;
      cnt_pi   = '0;
      ld_a     = 1'b0;
      ld_b     = 1'b0;
      add_en   = 1'b0;
      shift_en = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = INIT;
            end
         end
         INIT: begin
            ld_a = 1'b1;
            ld_b = 1'b1;
`ifdef MULT_ITER_CTRL_SHORT_ITER_EN
            cnt_ld = 1'b1;
            cnt_pi = pi_q;
`else
            cnt_clr = 1'b1;
`endif
            state_d = ADD;
         end
         ADD: begin
            // Counter output settled since the last increment was a cycle ago.
            if (cnt_co) begin
               state_d = DONE;
            end else begin
               add_en  = q0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            cnt_inc  = 1'b1;
            state_d  = ADD;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Reset must also clear the counter, which has no reset of its own.
      if (rst) begin
         cnt_clr = 1'b1;
      end
   end

endmodule

// File: tb/tb_mult_iter_ctrl.sv
// Directed bench for mult_iter_ctrl with a behavioural 6-bit iteration counter
// and shift-add datapath wired beside it.
module tb_mult_iter_ctrl;
   import mult_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             q0;
   logic             cnt_co;
   logic             cnt_clr, cnt_ld, cnt_inc;
   logic [CNT_W-1:0] cnt_pi;
   logic             ld_a, ld_b, add_en, shift_en, busy, done;
`ifdef MULT_ITER_CTRL_SHORT_ITER_EN
   logic [CNT_W-1:0] iter_n = '0;
`endif

   int total = 0;
   int bad   = 0;

   mult_iter_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .q0       (q0),
      .cnt_co   (cnt_co),
`ifdef MULT_ITER_CTRL_SHORT_ITER_EN
      .iter_n   (iter_n),
`endif
      .cnt_clr  (cnt_clr),
      .cnt_ld   (cnt_ld),
      .cnt_inc  (cnt_inc),
      .cnt_pi   (cnt_pi),
      .ld_a     (ld_a),
      .ld_b     (ld_b),
      .add_en   (add_en),
      .shift_en (shift_en),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Counter and datapath models.
   logic [CNT_W-1:0] cnt = '0;
   logic [31:0]      op_a = '0, op_b = '0, a_reg = '0;
   logic [64:0]      pr = '0;

   assign cnt_co = (cnt == 6'd32);
   assign q0     = pr[0];

   always @(posedge clk) begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_ld)  cnt <= cnt_pi;
      else if (cnt_inc) cnt <= cnt + 6'd1;

      if (ld_a) a_reg <= op_a;
      if (ld_b)          pr <= {33'd0, op_b};
      else if (add_en)   pr[64:32] <= {1'b0, pr[63:32]} + {1'b0, a_reg};
      else if (shift_en) pr <= pr >> 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts an operation in the current (IDLE) cycle and returns at the done cycle.
   task automatic run_op(input logic [31:0] opa, input logic [31:0] opb,
                         input logic [CNT_W-1:0] iter, input bit hold,
                         output int dcyc, output int incs, output int adds,
                         output int inits, output int busy_bad,
                         output logic [CNT_W-1:0] pi1, output logic ld1, output logic clr1);
      op_a = opa;
      op_b = opb;
`ifdef MULT_ITER_CTRL_SHORT_ITER_EN
      iter_n = iter;
`else
      if (iter != '0) op_a = opa;
`endif
      start    = 1'b1;
      dcyc     = -1;
      incs     = 0;
      adds     = 0;
      inits    = 0;
      busy_bad = 0;
      pi1      = '0;
      ld1      = 1'b0;
      clr1     = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         step();
         start = hold;
         if (c == 1) begin
            pi1  = cnt_pi;
            ld1  = cnt_ld;
            clr1 = cnt_clr;
         end
         if (cnt_inc) incs++;
         if (add_en)  adds++;
         if (ld_a)    inits++;
         if (!busy)   busy_bad++;
         if (done) begin
            dcyc = c;
            break;
         end
      end
   endtask

   int               dcyc, incs, adds, inits, busy_bad;
   logic [CNT_W-1:0] pi1;
   logic             ld1, clr1;
   logic [63:0]      exp_p;
   int               fin;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      step();
      step();
      // Reset state
      check("rst_cnt_clr", 64'(cnt_clr), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ctrl", 64'({cnt_ld, cnt_inc, ld_a, ld_b, add_en, shift_en}), 64'd0);
      check("rst_cnt_pi", 64'(cnt_pi), 64'd0);
      rst = 1'b0;
      step();
      check("idle_cnt_clr", 64'(cnt_clr), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      // 1: basic latency, increments, busy span
      run_op(32'd3, 32'd5, '0, 1'b0, dcyc, incs, adds, inits, busy_bad, pi1, ld1, clr1);
      check("t1_done_cycle", 64'(dcyc), 64'd67);
      check("t1_incs", 64'(incs), 64'd32);
      check("t1_busy_span", 64'(busy_bad), 64'd0);
`ifndef MULT_ITER_CTRL_SHORT_ITER_EN
      check("t1_init_clr", 64'(clr1), 64'd1);
      check("t1_init_ld", 64'(ld1), 64'd0);
      check("t1_init_pi", 64'(pi1), 64'd0);
`endif
      check("t1_product", pr[63:0], 64'd15);
      step();
      check("t1_idle_after", 64'(busy), 64'd0);

      // 2: multiplier 0xA5A5A5A5 -> 16 adds
      run_op(32'h1234_5678, 32'hA5A5_A5A5, '0, 1'b0, dcyc, incs, adds, inits, busy_bad,
             pi1, ld1, clr1);
      exp_p = 64'h0000_0000_1234_5678 * 64'h0000_0000_A5A5_A5A5;
      check("t2_adds", 64'(adds), 64'd16);
      check("t2_done_cycle", 64'(dcyc), 64'd67);
      check("t2_product", pr[63:0], exp_p);
      step();

      // 6: back-to-back with one IDLE cycle between
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 1'b0, dcyc, incs, adds, inits, busy_bad,
             pi1, ld1, clr1);
      check("t6a_product", pr[63:0], 64'hFFFF_FFFE_0000_0001);
      check("t6a_adds", 64'(adds), 64'd32);
      step();
      check("t6_gap_busy", 64'(busy), 64'd0);
      run_op(32'd1000, 32'd70000, '0, 1'b0, dcyc, incs, adds, inits, busy_bad,
             pi1, ld1, clr1);
      check("t6b_done_cycle", 64'(dcyc), 64'd67);
      check("t6b_product", pr[63:0], 64'd70000000);
      step();

      // 3: start held high
      run_op(32'd7, 32'd9, '0, 1'b1, dcyc, incs, adds, inits, busy_bad, pi1, ld1, clr1);
      check("t3_done_cycle", 64'(dcyc), 64'd67);
      check("t3_single_init", 64'(inits), 64'd1);
      check("t3_product", pr[63:0], 64'd63);
      step();
      check("t3_idle_busy", 64'(busy), 64'd0);
      check("t3_idle_no_init", 64'(ld_a), 64'd0);
      step();
      check("t3_restart_init", 64'(ld_a), 64'd1);
      start = 1'b0;
      fin = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (done) begin
            fin = 1;
            break;
         end
      end
      check("t3_restart_done", 64'(fin), 64'd1);
      step();

      // 4: reset mid-operation at cycle 20, then a clean operation
      op_a  = 32'd11;
      op_b  = 32'd13;
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      check("t4_clr_in_rst", 64'(cnt_clr), 64'd1);
      step();
      check("t4_busy_after_rst", 64'(busy), 64'd0);
      check("t4_clr_held", 64'(cnt_clr), 64'd1);
      check("t4_done_low", 64'(done), 64'd0);
      rst = 1'b0;
      #1;
      check("t4_clr_release", 64'(cnt_clr), 64'd0);
      check("t4_counter_zero", 64'(cnt), 64'd0);
      run_op(32'd11, 32'd13, '0, 1'b0, dcyc, incs, adds, inits, busy_bad, pi1, ld1, clr1);
      check("t4_done_cycle", 64'(dcyc), 64'd67);
      check("t4_product", pr[63:0], 64'd143);
      step();

`ifdef MULT_ITER_CTRL_SHORT_ITER_EN
      // 5: shortened iteration counts
      run_op(32'd3, 32'd5, 6'd5, 1'b0, dcyc, incs, adds, inits, busy_bad, pi1, ld1, clr1);
      check("t5_ld", 64'(ld1), 64'd1);
      check("t5_clr", 64'(clr1), 64'd0);
      check("t5_pi", 64'(pi1), 64'd27);
      check("t5_done_cycle", 64'(dcyc), 64'd13);
      check("t5_incs", 64'(incs), 64'd5);
      step();
      run_op(32'd3, 32'd5, 6'd0, 1'b0, dcyc, incs, adds, inits, busy_bad, pi1, ld1, clr1);
      check("t5z_pi", 64'(pi1), 64'd0);
      check("t5z_done_cycle", 64'(dcyc), 64'd67);
      check("t5z_product", pr[63:0], 64'd15);
      step();
      run_op(32'd3, 32'd5, 6'd40, 1'b0, dcyc, incs, adds, inits, busy_bad, pi1, ld1, clr1);
      check("t5o_pi", 64'(pi1), 64'd0);
      check("t5o_done_cycle", 64'(dcyc), 64'd67);
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
